// File: rtl/game_pkg.sv
// Shared types for the match/round sequencer.
// States, winner codes and the health width used by the health-bar stage.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNTDOWN,
    PLAY,
    KO,
    MATCH_END
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    CAT,
    DOG
  } winner_t;

  localparam int HP_W = 10;
  localparam logic [2:0] ROUND_MAX = 3'd7;

endpackage

// File: rtl/round_timer.sv
// Loadable down-counter for the countdown and KO freezes.
// Holds at zero until reloaded; done flags a zero count.
module round_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == '0);

endmodule

// File: rtl/round_ctrl.sv
// Match/round sequencer: KO detection, best-of-N scoring,
// health refill pulses and live-play gating.
module round_ctrl
  import game_pkg::*;
#(
  parameter int COUNTDOWN_CYC = 195_000_000,
  parameter int KO_CYC        = 130_000_000,
  parameter int ROUNDS_TO_WIN = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [HP_W-1:0] hp_cat,
  input  logic [HP_W-1:0] hp_dog,
  output logic            reset_hp,
  output logic            play_en,
  output logic [2:0]      round_num,
  output logic [1:0]      cat_wins,
  output logic [1:0]      dog_wins,
  output logic            match_over,
  output logic [1:0]      winner,
  output logic [2:0]      state_o
);

  localparam int MAXC = (COUNTDOWN_CYC > KO_CYC) ? COUNTDOWN_CYC : KO_CYC;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] CD_LOAD = TW'(COUNTDOWN_CYC - 1);
  localparam logic [TW-1:0] KO_LOAD = TW'(KO_CYC - 1);
  localparam logic [1:0]    WINS    = 2'(ROUNDS_TO_WIN);

  state_t      r_state;
  winner_t     r_winner;
  logic        r_start_q;
  logic        r_reset_hp;
  logic        r_play_en;
  logic        r_match_over;
  logic        r_draw;
  logic [2:0]  r_round;
  logic [1:0]  r_cat;
  logic [1:0]  r_dog;

  logic          w_start_rise;
  logic          w_ko_cat;
  logic          w_ko_dog;
  logic          w_decided;
  logic          w_done;
  logic          w_load;
  logic [TW-1:0] w_load_val;

  assign w_start_rise = start & ~r_start_q;
  assign w_ko_cat     = (hp_cat == '0);
  assign w_ko_dog     = (hp_dog == '0);
  assign w_decided    = (r_cat == WINS) || (r_dog == WINS);

  // Timer reloads mirror the FSM transitions that enter a freeze.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = CD_LOAD;
    unique case (r_state)
      IDLE, MATCH_END: w_load = w_start_rise;
      PLAY: begin
        if (w_ko_cat || w_ko_dog) begin
          w_load     = 1'b1;
          w_load_val = KO_LOAD;
        end
      end
      KO:      w_load = w_done && !w_decided;
      default: w_load = 1'b0;
    endcase
  end

  round_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .done     (w_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_winner     <= NONE;
      r_start_q    <= 1'b0;
      r_reset_hp   <= 1'b0;
      r_play_en    <= 1'b0;
      r_match_over <= 1'b0;
      r_draw       <= 1'b0;
      r_round      <= 3'd0;
      r_cat        <= 2'd0;
      r_dog        <= 2'd0;
    end else begin
      r_start_q  <= start;
      r_reset_hp <= 1'b0;
      unique case (r_state)
        IDLE, MATCH_END: begin
          if (w_start_rise) begin
            r_state      <= COUNTDOWN;
            r_winner     <= NONE;
            r_match_over <= 1'b0;
            r_reset_hp   <= 1'b1;
            r_round      <= 3'd1;
            r_cat        <= 2'd0;
            r_dog        <= 2'd0;
          end
        end
        COUNTDOWN: begin
          if (w_done) begin
            r_state   <= PLAY;
            r_play_en <= 1'b1;
          end
        end
        PLAY: begin
          if (w_ko_cat || w_ko_dog) begin
            r_state   <= KO;
            r_play_en <= 1'b0;
            r_draw    <= w_ko_cat && w_ko_dog;
            if (w_ko_cat && !w_ko_dog && r_dog != WINS)
              r_dog <= r_dog + 2'd1;
            if (w_ko_dog && !w_ko_cat && r_cat != WINS)
              r_cat <= r_cat + 2'd1;
          end
        end
        KO: begin
          if (w_done) begin
            if (w_decided) begin
              r_state      <= MATCH_END;
              r_match_over <= 1'b1;
              r_winner     <= (r_cat == WINS) ? CAT : DOG;
            end else begin
              r_state    <= COUNTDOWN;
              r_reset_hp <= 1'b1;
              if (!r_draw && r_round != ROUND_MAX)
                r_round <= r_round + 3'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign reset_hp   = r_reset_hp;
  assign play_en    = r_play_en;
  assign round_num  = r_round;
  assign cat_wins   = r_cat;
  assign dog_wins   = r_dog;
  assign match_over = r_match_over;
  assign winner     = r_winner;
  assign state_o    = r_state;

endmodule

// File: tb/tb_round_ctrl.sv
// Bench for round_ctrl with a health-bar model in the loop
// and a round/score scoreboard driven by random round outcomes.
module tb_round_ctrl;

  localparam int CD  = 4;
  localparam int KOC = 3;
  localparam int R2W = 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CD   = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_KO   = 3'd3;
  localparam logic [2:0] S_END  = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] hp_cat;
  logic [9:0] hp_dog;
  logic       reset_hp;
  logic       play_en;
  logic [2:0] round_num;
  logic [1:0] cat_wins;
  logic [1:0] dog_wins;
  logic       match_over;
  logic [1:0] winner;
  logic [2:0] state_o;

  logic       wr;
  logic [9:0] nxt_cat;
  logic [9:0] nxt_dog;

  int checks = 0;
  int errors = 0;
  int exp_round;
  int exp_cat;
  int exp_dog;
  int exp_win;

  round_ctrl #(
    .COUNTDOWN_CYC (CD),
    .KO_CYC        (KOC),
    .ROUNDS_TO_WIN (R2W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hp_cat     (hp_cat),
    .hp_dog     (hp_dog),
    .reset_hp   (reset_hp),
    .play_en    (play_en),
    .round_num  (round_num),
    .cat_wins   (cat_wins),
    .dog_wins   (dog_wins),
    .match_over (match_over),
    .winner     (winner),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  // Health-bar stage: refills one cycle after reset_hp, else takes bench writes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hp_cat <= 10'd500;
      hp_dog <= 10'd500;
    end else if (reset_hp) begin
      hp_cat <= 10'd500;
      hp_dog <= 10'd500;
    end else if (wr) begin
      hp_cat <= nxt_cat;
      hp_dog <= nxt_dog;
    end
  end

  task automatic apply_hp(input int c, input int d);
    nxt_cat = 10'(c);
    nxt_dog = 10'(d);
    wr = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic model_clear();
    exp_round = 1;
    exp_cat = 0;
    exp_dog = 0;
    exp_win = 0;
  endtask

  // outcome: 0 cat takes the round, 1 dog takes it, 2 double KO
  task automatic run_round(input int outcome);
    int n;
    int c;
    int d;
    n = $urandom_range(0, 3);
    repeat (n) begin
      apply_hp($urandom_range(1, 1023), $urandom_range(1, 1023));
      checks++;
      if (play_en !== 1'b1) begin
        errors++;
        $display("FAIL play_hold: play_en=%0b want 1", play_en);
      end
    end
    c = (outcome != 0) ? 0 : $urandom_range(1, 1023);
    d = (outcome != 1) ? 0 : $urandom_range(1, 1023);
    apply_hp(c, d);
    @(negedge clk);
    if (outcome == 0 && exp_cat < R2W) exp_cat++;
    if (outcome == 1 && exp_dog < R2W) exp_dog++;
    checks++;
    if (state_o !== S_KO || play_en !== 1'b0) begin
      errors++;
      $display("FAIL ko_entry: state=%0d play_en=%0b want %0d 0",
               state_o, play_en, S_KO);
    end
    checks++;
    if (cat_wins !== 2'(exp_cat) || dog_wins !== 2'(exp_dog)
        || round_num !== 3'(exp_round)) begin
      errors++;
      $display("FAIL scores: cat=%0d dog=%0d rnd=%0d want %0d %0d %0d",
               cat_wins, dog_wins, round_num, exp_cat, exp_dog, exp_round);
    end
    repeat (KOC - 1) begin
      @(negedge clk);
      checks++;
      if (state_o !== S_KO || reset_hp !== 1'b0) begin
        errors++;
        $display("FAIL ko_hold: state=%0d reset_hp=%0b want %0d 0",
                 state_o, reset_hp, S_KO);
      end
    end
    @(negedge clk);
    if (exp_cat == R2W || exp_dog == R2W) begin
      exp_win = (exp_cat == R2W) ? 1 : 2;
      checks++;
      if (state_o !== S_END || match_over !== 1'b1
          || winner !== 2'(exp_win)) begin
        errors++;
        $display("FAIL match_end: state=%0d over=%0b win=%0d want %0d 1 %0d",
                 state_o, match_over, winner, S_END, exp_win);
      end
    end else begin
      if (outcome != 2 && exp_round < 7) exp_round++;
      checks++;
      if (state_o !== S_CD || reset_hp !== 1'b1
          || round_num !== 3'(exp_round)) begin
        errors++;
        $display("FAIL next_round: state=%0d rhp=%0b rnd=%0d want %0d 1 %0d",
                 state_o, reset_hp, round_num, S_CD, exp_round);
      end
      repeat (CD) @(negedge clk);
      checks++;
      if (state_o !== S_PLAY || play_en !== 1'b1) begin
        errors++;
        $display("FAIL replay: state=%0d play_en=%0b want %0d 1",
                 state_o, play_en, S_PLAY);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    wr = 1'b0;
    nxt_cat = 10'd500;
    nxt_dog = 10'd500;
    repeat (3) @(negedge clk);
    checks++;
    if ({reset_hp, play_en, round_num, cat_wins, dog_wins,
         match_over, winner, state_o} !== 15'd0) begin
      errors++;
      $display("FAIL reset_vals: rhp=%0b pe=%0b rnd=%0d c=%0d d=%0d mo=%0b w=%0d st=%0d want all 0",
               reset_hp, play_en, round_num, cat_wins, dog_wins,
               match_over, winner, state_o);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (state_o !== S_IDLE || reset_hp !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: state=%0d rhp=%0b want 0 0", state_o, reset_hp);
    end
  endtask

  task automatic test_start();
    press_start();
    model_clear();
    checks++;
    if (reset_hp !== 1'b1 || round_num !== 3'd1 || state_o !== S_CD
        || play_en !== 1'b0) begin
      errors++;
      $display("FAIL start: rhp=%0b rnd=%0d st=%0d pe=%0b want 1 1 %0d 0",
               reset_hp, round_num, state_o, play_en, S_CD);
    end
    for (int i = 1; i < CD; i++) begin
      @(negedge clk);
      checks++;
      if (state_o !== S_CD || reset_hp !== 1'b0 || play_en !== 1'b0) begin
        errors++;
        $display("FAIL countdown: st=%0d rhp=%0b pe=%0b want %0d 0 0",
                 state_o, reset_hp, play_en, S_CD);
      end
    end
    @(negedge clk);
    checks++;
    if (state_o !== S_PLAY || play_en !== 1'b1) begin
      errors++;
      $display("FAIL play_entry: st=%0d pe=%0b want %0d 1",
               state_o, play_en, S_PLAY);
    end
  endtask

  task automatic test_cat_round();
    apply_hp(500, 50);
    checks++;
    if (state_o !== S_PLAY) begin
      errors++;
      $display("FAIL hp50: st=%0d want %0d", state_o, S_PLAY);
    end
    run_round(0);
  endtask

  task automatic test_draw();
    run_round(2);
  endtask

  task automatic test_ignore();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (state_o !== S_PLAY || reset_hp !== 1'b0
        || round_num !== 3'(exp_round)) begin
      errors++;
      $display("FAIL start_in_play: st=%0d rhp=%0b rnd=%0d want %0d 0 %0d",
               state_o, reset_hp, round_num, S_PLAY, exp_round);
    end
    apply_hp(0, 500);
    @(negedge clk);
    exp_dog++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (state_o !== S_KO || reset_hp !== 1'b0
        || dog_wins !== 2'(exp_dog)) begin
      errors++;
      $display("FAIL start_in_ko: st=%0d rhp=%0b dog=%0d want %0d 0 %0d",
               state_o, reset_hp, dog_wins, S_KO, exp_dog);
    end
    repeat (KOC - 1) @(negedge clk);
    exp_round++;
    checks++;
    if (state_o !== S_CD || round_num !== 3'(exp_round)) begin
      errors++;
      $display("FAIL ko_exit: st=%0d rnd=%0d want %0d %0d",
               state_o, round_num, S_CD, exp_round);
    end
    @(negedge clk);
    apply_hp(0, 0);
    apply_hp(500, 500);
    checks++;
    if (state_o !== S_CD || cat_wins !== 2'(exp_cat)
        || dog_wins !== 2'(exp_dog)) begin
      errors++;
      $display("FAIL hp0_in_cd: st=%0d c=%0d d=%0d want %0d %0d %0d",
               state_o, cat_wins, dog_wins, S_CD, exp_cat, exp_dog);
    end
    @(negedge clk);
    checks++;
    if (state_o !== S_PLAY || cat_wins !== 2'(exp_cat)
        || dog_wins !== 2'(exp_dog)) begin
      errors++;
      $display("FAIL cd_to_play: st=%0d c=%0d d=%0d want %0d %0d %0d",
               state_o, cat_wins, dog_wins, S_PLAY, exp_cat, exp_dog);
    end
  endtask

  task automatic test_match_end();
    run_round(0);
    press_start();
    model_clear();
    checks++;
    if (cat_wins !== 2'd0 || dog_wins !== 2'd0 || winner !== 2'd0
        || round_num !== 3'd1 || reset_hp !== 1'b1 || match_over !== 1'b0) begin
      errors++;
      $display("FAIL restart: c=%0d d=%0d w=%0d rnd=%0d rhp=%0b mo=%0b want 0 0 0 1 1 0",
               cat_wins, dog_wins, winner, round_num, reset_hp, match_over);
    end
    repeat (CD) @(negedge clk);
    checks++;
    if (state_o !== S_PLAY) begin
      errors++;
      $display("FAIL restart_play: st=%0d want %0d", state_o, S_PLAY);
    end
  endtask

  task automatic test_async_rst();
    apply_hp(0, 500);
    @(negedge clk);
    checks++;
    if (state_o !== S_KO) begin
      errors++;
      $display("FAIL pre_rst_ko: st=%0d want %0d", state_o, S_KO);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({reset_hp, play_en, round_num, cat_wins, dog_wins,
         match_over, winner, state_o} !== 15'd0) begin
      errors++;
      $display("FAIL async_rst: rhp=%0b pe=%0b rnd=%0d c=%0d d=%0d mo=%0b w=%0d st=%0d want all 0",
               reset_hp, play_en, round_num, cat_wins, dog_wins,
               match_over, winner, state_o);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (KOC + 1) begin
      @(negedge clk);
      checks++;
      if (state_o !== S_IDLE || reset_hp !== 1'b0) begin
        errors++;
        $display("FAIL post_rst: st=%0d rhp=%0b want 0 0", state_o, reset_hp);
      end
    end
  endtask

  task automatic test_random_matches();
    int pick;
    for (int m = 0; m < 4; m++) begin
      press_start();
      model_clear();
      checks++;
      if (reset_hp !== 1'b1 || round_num !== 3'd1 || winner !== 2'd0) begin
        errors++;
        $display("FAIL rnd_start: rhp=%0b rnd=%0d w=%0d want 1 1 0",
                 reset_hp, round_num, winner);
      end
      repeat (CD) @(negedge clk);
      for (int r = 0; r < 30 && state_o !== S_END; r++) begin
        pick = $urandom_range(0, 4);
        run_round(pick < 2 ? 0 : (pick < 4 ? 1 : 2));
      end
      checks++;
      if (state_o !== S_END) begin
        errors++;
        $display("FAIL match_timeout: st=%0d want %0d", state_o, S_END);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_cat_round();
    test_draw();
    test_ignore();
    test_match_end();
    test_async_rst();
    test_random_matches();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
